// File: rtl/if_ctrl.sv
// if_ctrl: fetch-stage sequencer arbitrating load-use stalls, redirects and a
// variable-latency instruction memory, with saturating stall/flush counters.
module if_ctrl #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_use_hazard,
    input  logic        is_jump,
    input  logic        branch_taken,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic        pc_write,
    output logic        pc_src,
    output logic        is_j,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        fetch_err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ERR   = 2'd2;

    logic [1:0]  r_state, w_next;
    logic [7:0]  r_wait;
    logic [15:0] r_stall, r_flush;
    logic        w_fetch, w_wait, w_hold, w_redir, w_miss;

    assign w_fetch = !rst && r_state == S_FETCH;
    assign w_wait  = !rst && r_state == S_WAIT;
    assign w_hold  = w_fetch && load_use_hazard;
    assign w_redir = w_fetch && !load_use_hazard && (is_jump || branch_taken);
    // A miss in WAIT keeps the same outputs even on the cycle that escalates to ERR.
    assign w_miss  = !imem_ready && (w_wait || (w_fetch && !load_use_hazard && !is_jump && !branch_taken));

    always_comb begin
        imem_req    = w_fetch || w_wait;
        pc_write    = imem_req && !w_hold && !w_miss;
        is_j        = w_redir && is_jump;
        pc_src      = w_redir && !is_jump;
        ifid_write  = imem_req && !w_hold;
        ifid_flush  = w_redir || w_miss;
        idex_bubble = w_hold;
        fetch_err   = !rst && r_state == S_ERR;
        stall_cnt   = rst ? 16'd0 : r_stall;
        flush_cnt   = rst ? 16'd0 : r_flush;
        w_next      = r_state;
        if (w_fetch && w_miss)
            w_next = S_WAIT;
        else if (w_wait)
            w_next = imem_ready ? S_FETCH : (r_wait == 8'(WAIT_LIMIT) ? S_ERR : S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_wait  <= 8'd0;
            r_stall <= 16'd0;
            r_flush <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_fetch && w_miss)
                r_wait <= 8'd1;
            else if (w_wait && w_miss)
                r_wait <= r_wait + 8'd1;
            if ((w_hold || w_miss) && r_stall != 16'hFFFF)
                r_stall <= r_stall + 16'd1;
            if (w_redir && r_flush != 16'hFFFF)
                r_flush <= r_flush + 16'd1;
        end
    end
endmodule

// File: tb/tb_if_ctrl.sv
// tb_if_ctrl: directed scoreboard bench for if_ctrl; expected outputs are queued
// when a step is driven and compared at the following falling edge.
module tb_if_ctrl;
    logic        clk = 1'b0;
    logic        rst, luh, jmp, br, rdy;
    logic        imem_req, pc_write, pc_src, is_j, ifid_write, ifid_flush, idex_bubble, fetch_err;
    logic [15:0] stall_cnt, flush_cnt;

    // ctl order: {imem_req, pc_write, pc_src, is_j, ifid_write, ifid_flush, idex_bubble, fetch_err}
    localparam logic [7:0] ZERO = 8'b0000_0000;
    localparam logic [7:0] NORM = 8'b1100_1000;
    localparam logic [7:0] HOLD = 8'b1000_0010;
    localparam logic [7:0] JMP  = 8'b1101_1100;
    localparam logic [7:0] BR   = 8'b1110_1100;
    localparam logic [7:0] MISS = 8'b1000_1100;
    localparam logic [7:0] ERRS = 8'b0000_0001;

    typedef struct {
        string       tag;
        logic [39:0] exp;
    } item_t;

    item_t       sb[$];
    int          tests = 0, fails = 0;
    logic [15:0] es = 16'd0, ef = 16'd0;

    always #5 clk = ~clk;

    if_ctrl #(.WAIT_LIMIT(15)) dut (
        .clk(clk), .rst(rst), .load_use_hazard(luh), .is_jump(jmp), .branch_taken(br),
        .imem_ready(rdy), .imem_req(imem_req), .pc_write(pc_write), .pc_src(pc_src),
        .is_j(is_j), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .fetch_err(fetch_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic step(input string tag, input logic r, input logic h, input logic j,
                        input logic b, input logic m, input logic [7:0] ctl,
                        input bit sinc, input bit finc);
        item_t       it;
        logic [39:0] obs;
        rst = r; luh = h; jmp = j; br = b; rdy = m;
        sb.push_back('{tag, {ctl, r ? 16'd0 : es, r ? 16'd0 : ef}});
        @(negedge clk);
        obs = {imem_req, pc_write, pc_src, is_j, ifid_write, ifid_flush, idex_bubble, fetch_err,
               stall_cnt, flush_cnt};
        it = sb.pop_front();
        tests++;
        assert (obs === it.exp) else begin
            fails++;
            $error("FAIL %s: got ctl=%b stall=%h flush=%h, want ctl=%b stall=%h flush=%h",
                   it.tag, obs[39:32], obs[31:16], obs[15:0], it.exp[39:32], it.exp[31:16], it.exp[15:0]);
        end
        if (r) begin
            es = 16'd0;
            ef = 16'd0;
        end else begin
            if (sinc && es != 16'hFFFF) es = es + 16'd1;
            if (finc && ef != 16'hFFFF) ef = ef + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        step("reset0", 1, 0, 0, 0, 1, ZERO, 0, 0);
        step("reset1", 1, 1, 1, 1, 0, ZERO, 0, 0);
        for (int i = 0; i < 10; i++) step("normal", 0, 0, 0, 0, 1, NORM, 0, 0);
        step("hazard_jmp0", 0, 1, 1, 0, 1, HOLD, 1, 0);
        step("hazard_jmp1", 0, 1, 1, 0, 1, HOLD, 1, 0);
        step("jump_after", 0, 0, 1, 0, 1, JMP, 0, 1);
        step("cnt_2_1", 0, 0, 0, 0, 1, NORM, 0, 0);
        step("jmp_over_br", 0, 0, 1, 1, 0, JMP, 0, 1);
        step("branch", 0, 0, 0, 1, 0, BR, 0, 1);
        step("miss_fetch", 0, 0, 0, 0, 0, MISS, 1, 0);
        step("miss_wait_br", 0, 1, 1, 1, 0, MISS, 1, 0);
        step("miss_wait", 0, 0, 0, 0, 0, MISS, 1, 0);
        step("wait_ready", 0, 1, 0, 1, 1, NORM, 0, 0);
        step("fetch_again", 0, 1, 0, 0, 1, HOLD, 1, 0);
        for (int i = 0; i < 16; i++) step("miss_to_err", 0, 0, 0, 0, 0, MISS, 1, 0);
        step("err0", 0, 0, 0, 0, 0, ERRS, 0, 0);
        step("err_sticky", 0, 1, 1, 1, 1, ERRS, 0, 0);
        step("err_rst", 1, 0, 0, 0, 1, ZERO, 0, 0);
        step("post_err", 0, 1, 0, 0, 1, HOLD, 1, 0);
        step("miss_pre_rst", 0, 0, 0, 0, 0, MISS, 1, 0);
        step("wait_rst", 1, 0, 0, 0, 0, ZERO, 0, 0);
        step("fetch_after", 0, 1, 0, 0, 1, HOLD, 1, 0);
        step("sat_rst", 1, 0, 0, 0, 1, ZERO, 0, 0);
        for (int i = 0; i < 32'h10001; i++) step("stall_sat", 0, 1, 0, 0, 1, HOLD, 1, 0);
        step("sat_final", 0, 0, 0, 0, 1, NORM, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/if_ctrl.md
# if_ctrl

Fetch-stage sequencer for the five-stage pipeline. It drives the PC write enable and PC source selects of the IF stage and the write/flush controls of the IF/ID register. It arbitrates between load-use stalls, jump/branch redirects and a variable-latency instruction memory. It also keeps saturating stall and flush performance counters, and latches a sticky error on instruction-memory timeout.

## Interface
Parameters:
- WAIT_LIMIT, 15: maximum consecutive not-ready cycles in WAIT before the error state is entered (legal range 1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_use_hazard  in  1  from ID hazard detection: the ID/EX load target matches an ID source register.
- is_jump  in  1  ID holds a J-type jump.
- branch_taken  in  1  ID resolved a taken branch.
- imem_ready  in  1  instruction memory returns a valid word for the current PC in this cycle.
- imem_req  out  1  fetch request for the current PC.
- pc_write  out  1  PC register load enable (PCWrite).
- pc_src  out  1  1 = load branch target.
- is_j  out  1  1 = load jump target (overrides pc_src in the datapath).
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  load a NOP into IF/ID instead of the fetched word (only meaningful with ifid_write=1).
- idex_bubble  out  1  zero the control fields entering ID/EX.
- fetch_err  out  1  sticky instruction-memory timeout flag.
- stall_cnt  out  16  saturating count of cycles with pc_write=0 in FETCH or WAIT.
- flush_cnt  out  16  saturating count of redirects (jump or taken branch).

## Operation
- States: FETCH, WAIT, ERR. The state register, a wait counter of 8 bits and both performance counters are registered.
- All outputs are combinational from the current state and inputs.
- While rst=1, every output is 0.

FETCH state: imem_req=1. Evaluate the following in priority order; only the first match applies.
1. load_use_hazard=1: pc_write=0, ifid_write=0, idex_bubble=1, increment stall_cnt. The branch/jump in ID is not acted on, because its operands are not ready. Stay in FETCH.
2. is_jump=1: pc_write=1, is_j=1, pc_src=0, ifid_write=1, ifid_flush=1, increment flush_cnt. Stay in FETCH. This applies regardless of imem_ready; the aborted fetch is discarded.
3. branch_taken=1: same as the jump case, but pc_src=1 and is_j=0.
4. imem_ready=0: pc_write=0, ifid_write=1, ifid_flush=1 (NOP into ID), increment stall_cnt. Load the wait counter with 1 and go to WAIT.
5. Otherwise: pc_write=1, ifid_write=1. All other outputs are 0.

WAIT state:
- ID holds a NOP, so load_use_hazard, is_jump and branch_taken are ignored.
- imem_req=1.
- If imem_ready=1: pc_write=1, ifid_write=1, go to FETCH.
- Else if wait counter = WAIT_LIMIT: go to ERR with outputs as in the not-ready case below.
- Else: pc_write=0, ifid_write=1, ifid_flush=1, increment stall_cnt and the wait counter.

ERR state:
- fetch_err=1.
- imem_req, pc_write, ifid_write, pc_src, is_j and idex_bubble are all 0.
- The only exit is rst.

Counters:
- Both counters are 16-bit and stick at 0xFFFF.
- Both clear only on rst.
- Counters do not increment in ERR.

Constraints:
- pc_src and is_j are never both 1.
- ifid_flush=1 implies ifid_write=1.

## Timing
- Reset is synchronous. In the first cycle with rst=0 the state is FETCH and the counters read 0.
- Outputs respond in the same cycle as the inputs, with zero latency.
- A redirect asserted in cycle N loads the PC at the edge ending cycle N. The target instruction is fetched in cycle N+1, and IF/ID holds a NOP during N+1.
- A load-use hazard held for k cycles freezes PC and IF/ID for exactly k cycles and inserts k bubbles.
- Memory latency of L not-ready cycles (L < WAIT_LIMIT+1) costs L stall cycles: 1 in FETCH plus L-1 in WAIT.
- fetch_err rises in the cycle after the WAIT_LIMIT-th not-ready cycle in WAIT, i.e. the cycle after WAIT is left for ERR.
- rst asserted in WAIT or ERR returns to FETCH on the next edge, clearing fetch_err and the counters.

## Test plan
- Reset, then imem_ready=1 held, no hazards for 10 cycles: pc_write=1 and ifid_write=1 every cycle; stall_cnt=0, flush_cnt=0.
- load_use_hazard=1 for 2 cycles with is_jump=1 also asserted: pc_write=0 and idex_bubble=1 in both cycles. The next cycle with hazard=0 gives is_j=1 and ifid_flush=1. Final stall_cnt=2, flush_cnt=1.
- branch_taken=1 and is_jump=1 together: is_j=1, pc_src=0, flush_cnt increments by 1.
- imem_ready=0 for 3 cycles, then 1: FETCH→WAIT, pc_write=0 for 3 cycles with ifid_flush=1, pc_write=1 in the 4th cycle, stall_cnt=3. branch_taken pulsed during WAIT has no effect.
- WAIT_LIMIT=15 and imem_ready held 0: fetch_err=1 from cycle 17 after the request starts, all enables 0. Then rst for 1 cycle: fetch_err=0 and the state is FETCH.
- Force stall_cnt to 0xFFFE via 0xFFFE hazard cycles, then 3 more: stall_cnt stays at 0xFFFF.
